// File: rtl/cpu_flags_pkg.sv
// Shared flag-bit positions and sizing helper for the CPU flag logic.
package cpu_flags_pkg;

  localparam int FLAG_D = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Width needed to count 0..depth occupied slots inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flag_lifo.sv
// DEPTH x NFLAGS save stack with an occupancy counter; slot data is not reset.
module flag_lifo
  import cpu_flags_pkg::*;
#(
  parameter int NFLAGS = 5,
  parameter int DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [NFLAGS-1:0]             wdata_i,
  output logic [NFLAGS-1:0]             rdata_o,
  output logic [level_width(DEPTH)-1:0] level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int LW = level_width(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [NFLAGS-1:0] mem_q [DEPTH];
  logic [LW-1:0]     level_q, level_d;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // Guarded locally as well so the counter can never leave 0..DEPTH.
  assign do_push = push_i && !pop_i && !full_o;
  assign do_pop  = pop_i && !push_i && !empty_o;

  assign wr_idx  = AW'(level_q);
  assign rd_idx  = AW'(level_q - LW'(1));
  assign rdata_o = mem_q[rd_idx];

  always_comb begin
    level_d = level_q;
    if (do_push) begin
      level_d = level_q + LW'(1);
    end else if (do_pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_idx] <= wdata_i;
    end
  end

endmodule

// File: rtl/flag_stack_unit.sv
// CPU flag register with per-bit clear/set/write priority and an interrupt save stack.
module flag_stack_unit
  import cpu_flags_pkg::*;
#(
  parameter int NFLAGS = 5,
  parameter int DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NFLAGS-1:0]             FLAGS,
  input  logic [NFLAGS-1:0]             FWE,
  input  logic [NFLAGS-1:0]             FSET,
  input  logic [NFLAGS-1:0]             FCLR,
  input  logic                          PUSH,
  input  logic                          POP,
  output logic [NFLAGS-1:0]             FOUT,
  output logic [level_width(DEPTH)-1:0] LEVEL,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic                          ERR
);

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [NFLAGS-1:0] top_data;
  logic              err_q, err_d;
  logic              push_ok, pop_ok, err_event;

  assign push_ok   = PUSH && !POP && !FULL;
  assign pop_ok    = POP && !PUSH && !EMPTY;
  assign err_event = (PUSH && POP) || (PUSH && FULL) || (POP && EMPTY);

  flag_lifo #(
    .NFLAGS (NFLAGS),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push_ok),
    .pop_i   (pop_ok),
    .wdata_i (flags_q),
    .rdata_o (top_data),
    .level_o (LEVEL),
    .full_o  (FULL),
    .empty_o (EMPTY)
  );

  // A restore overrides every per-bit update; otherwise clear beats set beats write.
  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = top_data;
    end else begin
      for (int i = 0; i < NFLAGS; i++) begin
        if (FCLR[i]) begin
          flags_d[i] = 1'b0;
        end else if (FSET[i]) begin
          flags_d[i] = 1'b1;
        end else if (FWE[i]) begin
          flags_d[i] = FLAGS[i];
        end
      end
    end
  end

  assign err_d = err_q | err_event;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign FOUT = flags_q;
  assign ERR  = err_q;

endmodule

// File: doc/flag_stack_unit.md
FLAG_STACK_UNIT -- requirements
Module: flag_stack_unit

Interface
REQ-001 SHALL have parameter NFLAGS, default 5, number of flag bits (bit 4 D, 3 C, 2 O, 1 N, 0 Z at default), legal range 1..16.
REQ-002 SHALL have parameter DEPTH, default 4, number of save slots in the flag stack, legal range 2..16.
REQ-003 SHALL have port CLK  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port FLAGS  input  NFLAGS  new flag values from the ALU.
REQ-006 SHALL have port FWE  input  NFLAGS  per-bit write enables; bit i loads FLAGS[i].
REQ-007 SHALL have port FSET  input  NFLAGS  per-bit force-to-1 mask (flag-set instruction).
REQ-008 SHALL have port FCLR  input  NFLAGS  per-bit force-to-0 mask (flag-clear instruction).
REQ-009 SHALL have port PUSH  input  1  save the current flags onto the stack (interrupt entry).
REQ-010 SHALL have port POP  input  1  restore the flags from the top of the stack (interrupt return).
REQ-011 SHALL have port FOUT  output  NFLAGS  current flag register value.
REQ-012 SHALL have port LEVEL  output  clog2(DEPTH+1)  number of occupied stack slots.
REQ-013 SHALL have ports FULL and EMPTY  output  1 each  LEVEL==DEPTH and LEVEL==0 respectively.
REQ-014 SHALL have port ERR  output  1  sticky flag for a stack-discipline violation.

Function
REQ-015 SHALL compute the next value of each flag bit i with this priority: RESET, then a valid POP (restore), then FCLR[i] (0), then FSET[i] (1), then FWE[i] (FLAGS[i]), otherwise hold.
REQ-016 SHALL make every update visible on FOUT one cycle after the qualifying edge; FOUT SHALL have no combinational path from any input.
REQ-017 SHALL treat PUSH as valid when !FULL and !POP; a valid PUSH SHALL write the pre-edge FOUT into slot LEVEL and increment LEVEL.
REQ-018 SHALL apply same-cycle FWE/FSET/FCLR to FOUT during a valid PUSH, so the stack holds the old value and FOUT holds the updated value.
REQ-019 SHALL treat POP as valid when !EMPTY and !PUSH; a valid POP SHALL load FOUT from slot LEVEL-1, decrement LEVEL, and ignore FWE/FSET/FCLR for all bits in that cycle.
REQ-020 SHALL, on PUSH while FULL, leave the stack, LEVEL and the overwrite-free state unchanged, apply any flag writes normally, and set ERR.
REQ-021 SHALL, on POP while EMPTY, leave FOUT, the stack and LEVEL unchanged, apply any flag writes normally, and set ERR.
REQ-022 SHALL, when PUSH and POP are asserted in the same cycle, perform no stack operation, apply any flag writes normally, and set ERR.
REQ-023 SHALL hold ERR at 1 once set, until RESET.
REQ-024 SHALL keep LEVEL within 0..DEPTH at all times; it SHALL never wrap.
REQ-025 SHALL leave stack slot contents undefined after reset; only LEVEL defines which slots are valid.

Reset
REQ-026 SHALL, on a rising CLK edge with RESET=1, set FOUT=0, LEVEL=0 (EMPTY=1, FULL=0) and ERR=0, overriding all other inputs, including mid-push or mid-pop.

Structure
REQ-027 SHALL take its flag bit-index constants (D, C, O, N, Z) and the LEVEL width function from a shared package, cpu_flags_pkg.
REQ-028 SHALL be built as one sub-module, flag_lifo (a DEPTH x NFLAGS register array with a level counter), plus the per-bit flag-update logic in the top module.

Verification
REQ-029 SHALL cover reset: drive FLAGS=5'h1F with FWE=5'h1F, then RESET -> FOUT=0, LEVEL=0, EMPTY=1, ERR=0.
REQ-030 SHALL cover a nested push and pop: FOUT=5'h0A, PUSH; FOUT=5'h15, PUSH; POP -> FOUT=5'h15; POP -> FOUT=5'h0A, LEVEL=0.
REQ-031 SHALL cover a same-cycle write during PUSH: FOUT=5'h03, PUSH with FSET=5'h10 -> FOUT=5'h13, and a later POP returns 5'h03.
REQ-032 SHALL cover overflow: with DEPTH=4, perform 5 PUSHes -> LEVEL=4, FULL=1, ERR=1, and the top slot still holds the 4th pushed value.
REQ-033 SHALL cover underflow and collision: POP while EMPTY -> FOUT unchanged, ERR=1; PUSH and POP together with LEVEL=2 -> LEVEL stays 2, ERR=1.
REQ-034 SHALL cover update priority: FCLR=5'h01, FSET=5'h01, FWE=5'h01, FLAGS=5'h01 -> Z=0; POP together with FSET=5'h1F -> FOUT equals the popped value.
